mips_cpu_bus_master: RTL and testbench
======================================

# mips_cpu_bus_master

Avalon memory-mapped bus master between the MIPS core and the unified bus memory. It accepts instruction-fetch and data load/store requests from the core, arbitrates them onto the single Avalon port, and honours `waitrequest`. For sub-word loads and stores it also generates byte lanes, and it sign- or zero-extends read data.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of WAIT cycles allowed (only used with the timeout macro).

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `fetch_req` in 1: instruction fetch request; held until `fetch_valid`.
- `fetch_addr` in 32: fetch byte address, word-aligned.
- `fetch_valid` out 1: one-cycle pulse; `fetch_instr` is valid in that cycle.
- `fetch_instr` out 32: fetched word; holds its value until the next fetch completes.
- `mem_req` in 1: data request; held until `mem_done`.
- `mem_we` in 1: 1 = store, 0 = load.
- `mem_size` in 2: access width (byte, half, word).
- `mem_signed` in 1: sign-extend loads.
- `mem_addr` in 32: data byte address.
- `mem_wdata` in 32: store data, right-justified.
- `mem_done` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: extended load result; holds its value until the next load completes.
- `mem_err` out 1: qualifies `mem_done`; set on misalignment or timeout.
- `address` out 32: Avalon address, always word-aligned.
- `read` out 1: Avalon read.
- `write` out 1: Avalon write.
- `waitrequest` in 1: Avalon wait request from the slave.
- `writedata` out 32: Avalon write data.
- `byteenable` out 4: Avalon byte enables.
- `readdata` in 32: Avalon read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: request inputs are sampled only in this state. If both requests are high, the data request wins. The accepted request's fields are captured into registers; the FSM moves to ISSUE. With no request, it stays in IDLE.
- Misaligned data request (half with `addr[0]`=1, or word with `addr[1:0]`≠0): no bus cycle is issued. The FSM goes straight to DONE with `mem_err`=1 and `mem_rdata`=0.
- ISSUE: `read` or `write` is asserted. `address` = captured address & ~3. `waitrequest` is ignored in this cycle. Next state is WAIT.
- WAIT: `read`/`write`, `address`, `writedata` and `byteenable` are held stable.
  - `waitrequest`=0 at the clock edge: the transfer completes and `readdata` is captured. `read`/`write` deassert; the FSM moves to DONE.
  - `waitrequest`=1: the FSM stays in WAIT.
- DONE: exactly one of `fetch_valid` or `mem_done` pulses. The FSM returns to IDLE.
- Lane mapping: lane k = `addr[1:0]`, driving `byteenable[k]` and bits [8k+7:8k].
  - Byte access: `byteenable` = 1<<k; `writedata` = `wdata[7:0]`<<8k.
  - Half access: `byteenable` = 4'b0011 or 4'b1100 (selected by `addr[1]`); `writedata` = `wdata[15:0]`<<16·`addr[1]`.
  - Word access: `byteenable` = 4'b1111.
  - Fetch: always a word read with `byteenable` = 4'b1111.
- Load extraction: `readdata`>>8k, truncated to the access size, then sign-extended if `mem_signed`=1, otherwise zero-extended.
- Stores: `mem_rdata` is unchanged.

## Timing
- Reset values: all outputs are 0 (`read`, `write`, `address`, `writedata`, `byteenable`, `fetch_*`, `mem_*`). State is IDLE.
- Reset asserted mid-transfer: `read`/`write` drop at that edge and the captured request is discarded. No `done`/`valid` pulse is produced.
- Minimum latency, request seen in IDLE at cycle 0: ISSUE at cycle 1, WAIT at cycle 2, DONE at cycle 3.
  - Each extra `waitrequest` cycle adds 1 to this latency.
  - A misaligned request reaches DONE at cycle 1.
- Requester handshake: the requester drops its request on the edge that ends the DONE cycle. No repeat transfer occurs as long as it does so.
  - Back-to-back throughput is one transfer per 4 cycles.
- Simultaneous requests: the fetch waits until the data transfer completes.

## Configuration
- `MIPS_BUS_MASTER_TIMEOUT_EN` defined:
  - An 8+ bit counter counts WAIT cycles.
  - When the count reaches `TIMEOUT_CYCLES`, `read`/`write` drop and the FSM goes to DONE with `mem_err`=1.
  - A fetch that times out pulses `fetch_valid` with `fetch_instr`=0, and also pulses `mem_err`.
- Macro undefined: the FSM waits in WAIT indefinitely and `mem_err` reports misalignment only.

## Structure
- Package `mips_cpu_bus_pkg`:
  - size encoding `SIZE_BYTE`=2'b00, `SIZE_HALF`=2'b01, `SIZE_WORD`=2'b10;
  - FSM state enum;
  - `RESET_VECTOR`=32'hBFC00000.
- Sub-module `mips_cpu_bus_lane`: combinational lane steering, covering `byteenable`/`writedata` generation and load extraction/extension.

## Test plan
- Fetch at 0xBFC00000, word 0x24020005, slave holds `waitrequest` for 2 cycles → `fetch_valid` at cycle 5, `fetch_instr`=0x24020005, `byteenable`=4'b1111.
- `fetch_req` and `mem_req` (load word at 0x1000) asserted in the same cycle → data read is issued first, `mem_done` arrives before `fetch_valid`, and the two transfers do not overlap.
- Word 0x8899AABB at 0x1000:
  - signed byte load at 0x1001 → `mem_rdata`=0xFFFFFFAA;
  - unsigned half load at 0x1002 → `mem_rdata`=0x00008899.
- Byte store of 0x12345677 to 0x1003 → `byteenable`=4'b1000, `writedata[31:24]`=0x77; memory word becomes 0x7799AABB.
- Half load at 0x1001 → no `read` asserted, `mem_done`=`mem_err`=1 at cycle 1, `mem_rdata`=0.
- `reset_n` low during WAIT → `read`=0 on the next edge, no `done` pulse. With the timeout macro defined and `waitrequest` stuck high, `mem_err` pulses after `TIMEOUT_CYCLES` WAIT cycles.

Source files
------------

// File: rtl/mips_cpu_bus_pkg.sv
// Shared definitions for the MIPS Avalon bus master: access-size encoding,
// FSM state type, reset vector and the alignment rule.
package mips_cpu_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } bus_state_t;

  // Half-words need an even address, words a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_bus_lane.sv
// Combinational byte-lane steering: byteenable/writedata for stores and
// extraction plus sign/zero extension for loads. Lane k = addr[1:0].
module mips_cpu_bus_lane
  import mips_cpu_bus_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_readdata,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_writedata,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  // Steer store data onto its lanes and pull load data down from them
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case leaves a latch behind.
    w_shifted    = i_readdata >> {i_addr_lo, 3'b000};
    o_byteenable = 4'b1111;
    o_writedata  = i_wdata;
    o_load_data  = w_shifted;
    case (i_size)
      SIZE_BYTE: begin
        o_byteenable = 4'b0001 << i_addr_lo;
        o_writedata  = {24'h0, i_wdata[7:0]} << {i_addr_lo, 3'b000};
        o_load_data  = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
      end
      SIZE_HALF: begin
        o_byteenable = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_writedata  = i_addr_lo[1] ? {i_wdata[15:0], 16'h0} : {16'h0, i_wdata[15:0]};
        o_load_data  = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_master.sv
// Avalon-MM bus master for the MIPS core. Arbitrates instruction fetch and
// data load/store onto one Avalon port (data wins ties), honours waitrequest
// and rejects misaligned data accesses without a bus cycle.
// Optional: define MIPS_BUS_MASTER_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYCLES WAIT cycles and report it through mem_err.
module mips_cpu_bus_master
  import mips_cpu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  bus_state_t  r_state, w_next_state;
  logic        r_is_fetch, r_we, r_signed, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_fetch_instr, r_mem_rdata;

  logic        w_mem_misaligned;
  logic        w_timeout;
  logic [3:0]  w_lane_be;
  logic [31:0] w_lane_wdata, w_load_data;

  assign w_mem_misaligned = is_misaligned(mem_size, mem_addr[1:0]);

`ifdef MIPS_BUS_MASTER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_wait_cnt;

  assign w_timeout = (r_state == ST_WAIT) && waitrequest &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count stalled WAIT cycles; restarts with every new bus cycle
  always_ff @(posedge clk) begin
    if (!reset_n)                          r_wait_cnt <= '0;
    else if (r_state == ST_ISSUE)          r_wait_cnt <= '0;
    else if (r_state == ST_WAIT && waitrequest) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  mips_cpu_bus_lane u_lane (
    .i_addr_lo    (r_addr[1:0]),
    .i_size       (r_size),
    .i_signed     (r_signed),
    .i_wdata      (r_wdata),
    .i_readdata   (readdata),
    .o_byteenable (w_lane_be),
    .o_writedata  (w_lane_wdata),
    .o_load_data  (w_load_data)
  );

  // State register; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state decode and bus/handshake outputs, all derived from the state
  always_comb begin
    w_next_state = r_state;
    read         = 1'b0;
    write        = 1'b0;
    address      = '0;
    writedata    = '0;
    byteenable   = '0;
    fetch_valid  = 1'b0;
    mem_done     = 1'b0;
    mem_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_req)        w_next_state = w_mem_misaligned ? ST_DONE : ST_ISSUE;
        else if (fetch_req) w_next_state = ST_ISSUE;
      end
      ST_ISSUE, ST_WAIT: begin
        read       = !r_we;
        write      = r_we;
        address    = {r_addr[31:2], 2'b00};
        writedata  = w_lane_wdata;
        byteenable = w_lane_be;
        if (r_state == ST_ISSUE)              w_next_state = ST_WAIT;
        else if (!waitrequest || w_timeout)   w_next_state = ST_DONE;
      end
      ST_DONE: begin
        fetch_valid  = r_is_fetch;
        mem_done     = !r_is_fetch;
        mem_err      = r_err;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Capture the accepted request in IDLE and the returned data at completion
  always_ff @(posedge clk) begin
    // NOTE: the request and result registers are reset too, since fetch_instr/mem_rdata must read 0 out of reset.
    if (!reset_n) begin
      r_is_fetch    <= 1'b0;
      r_we          <= 1'b0;
      r_size        <= SIZE_WORD;
      r_signed      <= 1'b0;
      r_addr        <= RESET_VECTOR;
      r_wdata       <= '0;
      r_err         <= 1'b0;
      r_fetch_instr <= '0;
      r_mem_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_req) begin
            r_is_fetch <= 1'b0;
            r_we       <= mem_we;
            r_size     <= mem_size;
            r_signed   <= mem_signed;
            r_addr     <= mem_addr;
            r_wdata    <= mem_wdata;
            r_err      <= w_mem_misaligned;
            if (w_mem_misaligned) r_mem_rdata <= '0;
          end else if (fetch_req) begin
            r_is_fetch <= 1'b1;
            r_we       <= 1'b0;
            r_size     <= SIZE_WORD;
            r_signed   <= 1'b0;
            r_addr     <= fetch_addr;
            r_err      <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!waitrequest) begin
            if (r_is_fetch) r_fetch_instr <= readdata;
            else if (!r_we) r_mem_rdata   <= w_load_data;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (r_is_fetch) r_fetch_instr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign fetch_instr = r_fetch_instr;
  assign mem_rdata   = r_mem_rdata;

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Self-checking bench for mips_cpu_bus_master: directed scenarios followed by
// random loads/stores/fetches, checked against a byte-level memory model.
module tb_mips_cpu_bus_master;
  import mips_cpu_bus_pkg::*;

  localparam int TB_TIMEOUT = 20;

  logic        clk, reset_n;
  logic        fetch_req, fetch_valid;
  logic [31:0] fetch_addr, fetch_instr;
  logic        mem_req, mem_we, mem_signed, mem_done, mem_err;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] model_last_rdata, model_last_instr;
  int          slave_wait = 0;
  int          slave_cnt  = 0;
  bit          slave_busy = 0;

  mips_cpu_bus_master #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Avalon slave: stalls slave_wait cycles after the first bus cycle, serves reads, commits writes
  always @(negedge clk) begin
    if (read || write) begin
      slave_cnt   = slave_busy ? slave_cnt + 1 : 0;
      slave_busy  = 1'b1;
      waitrequest = (slave_cnt <= slave_wait);
      readdata    = slave_mem.exists(address) ? slave_mem[address] : 32'hDEAD_BEEF;
      if (write && !waitrequest) begin
        logic [31:0] w;
        w = slave_mem.exists(address) ? slave_mem[address] : 32'h0;
        for (int i = 0; i < 4; i++)
          if (byteenable[i]) w[8*i +: 8] = writedata[8*i +: 8];
        slave_mem[address] = w;
      end
    end else begin
      slave_busy  = 1'b0;
      waitrequest = 1'b0;
      readdata    = $urandom;
    end
  end

  function automatic int size_bytes(input logic [1:0] size);
    return (size == SIZE_BYTE) ? 1 : (size == SIZE_HALF) ? 2 : 4;
  endfunction

  task automatic run_mem(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int wt);
    int          nb, k, done_cyc, fv_pulses;
    logic        mis, saw_bus, b_we, unstable, got_err;
    logic [3:0]  exp_be, b_be;
    logic [31:0] mask, exp_wd, exp_rd, w, b_addr, b_wd, got_rd, got_instr;
    nb  = size_bytes(size);
    k   = int'(addr[1:0]);
    mis = (nb == 2 && addr[0]) || (nb == 4 && k != 0);
    mask   = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    exp_be = 4'(((1 << nb) - 1) << k);
    exp_wd = (wdata & mask) << (8 * k);
    w      = model_mem[{addr[31:2], 2'b00}];
    if (mis) exp_rd = 32'h0;
    else if (we) exp_rd = model_last_rdata;
    else begin
      exp_rd = (w >> (8 * k)) & mask;
      if (sgn && exp_rd[8*nb-1]) exp_rd = exp_rd | ~mask;
    end
    slave_wait = wt;
    saw_bus = 0; b_we = 0; unstable = 0; got_err = 0; done_cyc = -1; fv_pulses = 0;
    b_be = '0; b_addr = '0; b_wd = '0; got_rd = '0; got_instr = '0;
    @(negedge clk);
    mem_req = 1; mem_we = we; mem_size = size; mem_signed = sgn; mem_addr = addr; mem_wdata = wdata;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (read || write) begin
        if (!saw_bus) begin
          saw_bus = 1; b_we = write; b_addr = address; b_be = byteenable; b_wd = writedata;
        end else if (write != b_we || address != b_addr || byteenable != b_be || writedata != b_wd)
          unstable = 1;
      end
      if (fetch_valid) fv_pulses++;
      if (mem_done) begin
        done_cyc = c; got_err = mem_err; got_rd = mem_rdata; got_instr = fetch_instr;
        break;
      end
    end
    mem_req = 0;
    check("mem_latency", done_cyc, 3 + wt - (mis ? 2 + wt : 0));
    check("mem_err", got_err, mis);
    check("mem_rdata", got_rd, exp_rd);
    check("fetch_instr_held", got_instr, model_last_instr);
    check("no_fetch_pulse", fv_pulses, 0);
    check("bus_issued", saw_bus, !mis);
    if (!mis) begin
      check("bus_dir", b_we, we);
      check("bus_addr", b_addr, {addr[31:2], 2'b00});
      check("bus_be", b_be, exp_be);
      if (we) check("bus_wdata", b_wd, exp_wd);
      check("bus_stable", unstable, 0);
      if (we) begin
        for (int i = 0; i < nb; i++) w[8*(k+i) +: 8] = wdata[8*i +: 8];
        model_mem[{addr[31:2], 2'b00}] = w;
      end
    end
    model_last_rdata = exp_rd;
  endtask

  task automatic run_fetch(input logic [31:0] addr, input int wt);
    int          done_cyc, md_pulses;
    logic        saw_bus, b_we;
    logic [3:0]  b_be;
    logic [31:0] b_addr, got_instr, got_rd;
    slave_wait = wt;
    saw_bus = 0; b_we = 0; b_be = '0; b_addr = '0; done_cyc = -1; md_pulses = 0;
    got_instr = '0; got_rd = '0;
    @(negedge clk);
    fetch_req = 1; fetch_addr = addr;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if ((read || write) && !saw_bus) begin
        saw_bus = 1; b_we = write; b_addr = address; b_be = byteenable;
      end
      if (mem_done) md_pulses++;
      if (fetch_valid) begin
        done_cyc = c; got_instr = fetch_instr; got_rd = mem_rdata;
        break;
      end
    end
    fetch_req = 0;
    check("fetch_latency", done_cyc, 3 + wt);
    check("fetch_instr", got_instr, model_mem[addr]);
    check("fetch_dir", b_we, 0);
    check("fetch_addr", b_addr, addr);
    check("fetch_be", b_be, 4'b1111);
    check("mem_rdata_held", got_rd, model_last_rdata);
    check("no_mem_pulse", md_pulses, 0);
    model_last_instr = model_mem[addr];
  endtask

  // Fetch and data word load raised together: data first, then the fetch
  task automatic run_both(input logic [31:0] faddr, input logic [31:0] laddr, input int wt);
    int          md_cyc, fv_cyc;
    logic        saw_bus;
    logic [31:0] first_addr, got_rd, got_instr;
    slave_wait = wt;
    md_cyc = -1; fv_cyc = -1; saw_bus = 0; first_addr = '0; got_rd = '0; got_instr = '0;
    @(negedge clk);
    fetch_req = 1; fetch_addr = faddr;
    mem_req = 1; mem_we = 0; mem_size = SIZE_WORD; mem_signed = 0; mem_addr = laddr; mem_wdata = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if ((read || write) && !saw_bus) begin saw_bus = 1; first_addr = address; end
      if (mem_done) begin md_cyc = c; got_rd = mem_rdata; mem_req = 0; end
      if (fetch_valid) begin fv_cyc = c; got_instr = fetch_instr; break; end
    end
    fetch_req = 0; mem_req = 0;
    check("both_first_addr", first_addr, laddr);
    check("both_mem_cycle", md_cyc, 3 + wt);
    check("both_fetch_cycle", fv_cyc, 7 + 2 * wt);
    check("both_rdata", got_rd, model_mem[laddr]);
    check("both_instr", got_instr, model_mem[faddr]);
    model_last_rdata = model_mem[laddr];
    model_last_instr = model_mem[faddr];
  endtask

  initial begin
    int pulses;
    reset_n = 0; fetch_req = 0; fetch_addr = '0;
    mem_req = 0; mem_we = 0; mem_size = SIZE_WORD; mem_signed = 0; mem_addr = '0; mem_wdata = '0;
    waitrequest = 0; readdata = '0;
    model_last_rdata = '0; model_last_instr = '0;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = $urandom;
      slave_mem[32'h1000 + 4 * i] = v;
      model_mem[32'h1000 + 4 * i] = v;
    end
    slave_mem[32'h1000] = 32'h8899_AABB;  model_mem[32'h1000] = 32'h8899_AABB;
    slave_mem[RESET_VECTOR] = 32'h2402_0005; model_mem[RESET_VECTOR] = 32'h2402_0005;

    repeat (3) @(negedge clk);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_address", address, 0);
    check("rst_writedata", writedata, 0);
    check("rst_byteenable", byteenable, 0);
    check("rst_handshake", {fetch_valid, mem_done, mem_err}, 0);
    check("rst_fetch_instr", fetch_instr, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    reset_n = 1;

    run_fetch(RESET_VECTOR, 2);
    run_both(RESET_VECTOR, 32'h1000, 1);
    run_mem(0, SIZE_BYTE, 1, 32'h1001, 32'h0, 0);
    run_mem(0, SIZE_HALF, 0, 32'h1002, 32'h0, 1);
    run_mem(1, SIZE_BYTE, 0, 32'h1003, 32'h1234_5677, 0);
    run_mem(0, SIZE_WORD, 0, 32'h1000, 32'h0, 0);
    check("store_merge", model_mem[32'h1000], 32'h7799_AABB);
    check("slave_word", slave_mem[32'h1000], 32'h7799_AABB);
    run_mem(0, SIZE_HALF, 0, 32'h1001, 32'h0, 0);

    // Reset while the slave is stalling a load
    slave_wait = 6;
    @(negedge clk);
    mem_req = 1; mem_we = 0; mem_size = SIZE_WORD; mem_signed = 0; mem_addr = 32'h1000;
    repeat (3) @(negedge clk);
    check("rst_mid_pre_read", read, 1);
    reset_n = 0;
    @(negedge clk);
    check("rst_mid_read", read, 0);
    check("rst_mid_done", mem_done, 0);
    reset_n = 1; mem_req = 0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_done || fetch_valid || read || write) pulses++;
    end
    check("rst_mid_quiet", pulses, 0);
    check("rst_mid_rdata", mem_rdata, 0);
    model_last_rdata = '0; model_last_instr = '0;

`ifdef MIPS_BUS_MASTER_TIMEOUT_EN
    begin
      int to_cyc;
      logic to_err;
      to_cyc = -1; to_err = 0;
      slave_wait = 100000;
      @(negedge clk);
      mem_req = 1; mem_we = 0; mem_size = SIZE_WORD; mem_addr = 32'h1000;
      for (int c = 1; c <= 200; c++) begin
        @(negedge clk);
        if (mem_done) begin to_cyc = c; to_err = mem_err; break; end
      end
      mem_req = 0;
      check("timeout_cycle", to_cyc, TB_TIMEOUT + 2);
      check("timeout_err", to_err, 1);
      model_last_rdata = mem_rdata;
    end
`endif

    for (int n = 0; n < 60; n++) begin
      int wt;
      wt = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        run_fetch(32'h1000 + 4 * $urandom_range(0, 15), wt);
      else
        run_mem(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                32'h1000 + $urandom_range(0, 63), $urandom, wt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
